// File: rtl/preg_alloc_scheduler.sv
// Round-robin arbiter sharing the free-list allocation port between rename requesters,
// with INIT/RECOVER sequencing after rst/flush. Optional counters: define PREG_ALLOC_PERF_EN.
module preg_alloc_scheduler #(
    parameter int NUM_REGS       = 64,
    parameter int NUM_REQ        = 2,
    parameter int RECOVER_CYCLES = 2,
    localparam int PW            = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt_valid,
    output logic [PW-1:0]      gnt_preg,
    output logic               alloc_ready,
    output logic               fl_need_free_reg,
    input  logic [PW-1:0]      fl_free_reg,
    input  logic               fl_reg_available,
`ifdef PREG_ALLOC_PERF_EN
    output logic [31:0]        starve_cnt,
    output logic [31:0]        grant_cnt,
`endif
    output logic [1:0]         dbg_state
);

    localparam int RW = $clog2(NUM_REQ);
    localparam logic [3:0] RELOAD = 4'(RECOVER_CYCLES);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [RW-1:0] rr_ptr;
    logic [RW-1:0] win;
    logic          fire;

    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= RELOAD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // flush always wins over the countdown, so repeated flushes keep us parked in RECOVER
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = ST_RECOVER;
            cnt_d   = RELOAD;
        end else if (state_q != ST_RUN) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = ST_RUN;
        end
    end

    // Handshake: req[i] is a level held until gnt_valid[i] pulses; fl_need_free_reg is the
    // valid strobe to the free list and is only raised when fl_reg_available is high.
    always_comb begin
        alloc_ready      = (state_q == ST_RUN) && fl_reg_available;
        fire             = alloc_ready && (|req) && !flush;
        fl_need_free_reg = fire;
    end

    always_comb begin
        int idx;
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = RW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            gnt_valid <= '0;
            gnt_preg  <= '0;
        end else begin
            gnt_valid <= '0;
            if (fire) begin
                gnt_valid <= NUM_REQ'(1) << win;
                gnt_preg  <= fl_free_reg;
                rr_ptr    <= (win == RW'(NUM_REQ - 1)) ? '0 : win + RW'(1);
            end
        end
    end

`ifdef PREG_ALLOC_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            grant_cnt  <= '0;
        end else begin
            if ((state_q == ST_RUN) && (|req) && !fl_reg_available && (starve_cnt != '1))
                starve_cnt <= starve_cnt + 32'd1;
            if (fire && (grant_cnt != '1))
                grant_cnt <= grant_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_preg_alloc_scheduler.sv
// Bench for preg_alloc_scheduler: directed vector table for the multi-cycle corners, then
// random stimulus checked against a cycle-count/queue reference model.
module tb_preg_alloc_scheduler;

    localparam int NUM_REGS = 64;
    localparam int NUM_REQ  = 2;
    localparam int RC       = 2;
    localparam int PW       = 6;
    localparam int GW       = NUM_REQ + PW;

    logic               clk = 1'b0;
    logic               rst, flush;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt_valid;
    logic [PW-1:0]      gnt_preg;
    logic               alloc_ready, fl_need_free_reg;
    logic [PW-1:0]      fl_free_reg;
    logic               fl_reg_available;
    logic [1:0]         dbg_state;
`ifdef PREG_ALLOC_PERF_EN
    logic [31:0]        starve_cnt, grant_cnt;
`endif

    preg_alloc_scheduler #(.NUM_REGS(NUM_REGS), .NUM_REQ(NUM_REQ), .RECOVER_CYCLES(RC)) dut (
        .clk(clk), .rst(rst), .flush(flush), .req(req),
        .gnt_valid(gnt_valid), .gnt_preg(gnt_preg),
        .alloc_ready(alloc_ready), .fl_need_free_reg(fl_need_free_reg),
        .fl_free_reg(fl_free_reg), .fl_reg_available(fl_reg_available),
`ifdef PREG_ALLOC_PERF_EN
        .starve_cnt(starve_cnt), .grant_cnt(grant_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic               rst, flush;
        logic [NUM_REQ-1:0] req;
        logic               avail;
        logic [PW-1:0]      free;
        logic               exp_need, exp_ready;
        logic [NUM_REQ-1:0] exp_gv;
        logic [PW-1:0]      exp_gp;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(input logic r, input logic f, input logic [1:0] rq, input logic av,
                                input int fr, input logic nd, input logic rd,
                                input logic [1:0] gv, input int gp);
        vec_t v;
        v.rst = r; v.flush = f; v.req = rq; v.avail = av; v.free = PW'(fr);
        v.exp_need = nd; v.exp_ready = rd; v.exp_gv = gv; v.exp_gp = PW'(gp);
        return v;
    endfunction

    // driver tasks
    task automatic drive(input logic r, input logic f, input logic [NUM_REQ-1:0] rq,
                         input logic av, input logic [PW-1:0] fr);
        @(negedge clk);
        rst = r; flush = f; req = rq; fl_reg_available = av; fl_free_reg = fr;
        #1;
    endtask

    task automatic apply_vec(input int k);
        string s;
        drive(tbl[k].rst, tbl[k].flush, tbl[k].req, tbl[k].avail, tbl[k].free);
        s = $sformatf("vec%0d", k);
        check({s, " fl_need"},   fl_need_free_reg, tbl[k].exp_need);
        check({s, " ready"},     alloc_ready,      tbl[k].exp_ready);
        check({s, " gnt_valid"}, gnt_valid,        tbl[k].exp_gv);
        check({s, " gnt_preg"},  gnt_preg,         tbl[k].exp_gp);
`ifdef PREG_ALLOC_PERF_EN
        if (k == 14) check("starve_cnt after 3 empty cycles", starve_cnt, 32'd3);
`endif
    endtask

    // reference model: cycles still blocked, round-robin pointer, expected registered outputs
    int m_blocked;
    int m_rr;
    int m_preg;
    int m_starve, m_grant;
    logic [GW-1:0] exp_q[$];

    function automatic int m_winner(input logic [NUM_REQ-1:0] r);
        for (int k = 0; k < NUM_REQ; k++)
            if (r[(m_rr + k) % NUM_REQ]) return (m_rr + k) % NUM_REQ;
        return -1;
    endfunction

    task automatic rand_step(input bit do_check, input bit force_rst);
        logic [GW-1:0]      e;
        logic [NUM_REQ-1:0] oh;
        logic               fire;
        int                 w;
        drive(force_rst || ($urandom_range(0, 63) == 0), ($urandom_range(0, 9) == 0),
              NUM_REQ'($urandom), ($urandom_range(0, 3) != 0), PW'($urandom));
        w    = m_winner(req);
        fire = (m_blocked == 0) && (req != 0) && fl_reg_available && !flush;
        if (do_check) begin
            e = exp_q.pop_front();
            check("rand gnt_valid", gnt_valid, e[GW-1:PW]);
            check("rand gnt_preg", gnt_preg, e[PW-1:0]);
            check("rand alloc_ready", alloc_ready, (m_blocked == 0) && fl_reg_available);
            check("rand fl_need", fl_need_free_reg, fire);
`ifdef PREG_ALLOC_PERF_EN
            check("rand starve_cnt", starve_cnt, m_starve);
            check("rand grant_cnt", grant_cnt, m_grant);
`endif
        end else begin
            exp_q.delete();
        end
        if (rst) begin
            m_blocked = RC; m_rr = 0; m_preg = 0; m_starve = 0; m_grant = 0;
            exp_q.push_back('0);
        end else begin
            if ((m_blocked == 0) && (req != 0) && !fl_reg_available) m_starve++;
            oh = '0;
            if (fire) begin
                oh[w]  = 1'b1;
                m_preg = fl_free_reg;
                m_rr   = (w + 1) % NUM_REQ;
                m_grant++;
            end
            exp_q.push_back({oh, PW'(m_preg)});
            if (flush) m_blocked = RC;
            else if (m_blocked > 0) m_blocked--;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req = '0; fl_reg_available = 1'b0; fl_free_reg = '0;
        repeat (2) @(negedge clk);

        //              rst flush req   av  free need rdy gv     gp
        tbl[0]  = mk(1, 0, 2'b01, 1, 32, 0, 0, 2'b00, 0);
        tbl[1]  = mk(0, 0, 2'b01, 1, 32, 0, 0, 2'b00, 0);
        tbl[2]  = mk(0, 0, 2'b01, 1, 32, 0, 0, 2'b00, 0);
        tbl[3]  = mk(0, 0, 2'b01, 1, 32, 1, 1, 2'b00, 0);
        tbl[4]  = mk(0, 0, 2'b10, 1, 31, 1, 1, 2'b01, 32);
        tbl[5]  = mk(0, 0, 2'b11, 1, 33, 1, 1, 2'b10, 31);
        tbl[6]  = mk(0, 0, 2'b11, 1, 34, 1, 1, 2'b01, 33);
        tbl[7]  = mk(0, 0, 2'b11, 1, 35, 1, 1, 2'b10, 34);
        tbl[8]  = mk(0, 0, 2'b11, 1, 36, 1, 1, 2'b01, 35);
        tbl[9]  = mk(0, 0, 2'b00, 1, 0,  0, 1, 2'b10, 36);
        tbl[10] = mk(0, 0, 2'b00, 1, 0,  0, 1, 2'b00, 36);
        tbl[11] = mk(0, 0, 2'b10, 0, 0,  0, 0, 2'b00, 36);
        tbl[12] = mk(0, 0, 2'b10, 0, 0,  0, 0, 2'b00, 36);
        tbl[13] = mk(0, 0, 2'b10, 0, 0,  0, 0, 2'b00, 36);
        tbl[14] = mk(0, 0, 2'b10, 1, 50, 1, 1, 2'b00, 36);
        tbl[15] = mk(0, 0, 2'b00, 1, 0,  0, 1, 2'b10, 50);
        tbl[16] = mk(0, 0, 2'b01, 1, 20, 1, 1, 2'b00, 50);
        tbl[17] = mk(0, 1, 2'b01, 1, 21, 0, 1, 2'b01, 20);
        tbl[18] = mk(0, 0, 2'b01, 1, 21, 0, 0, 2'b00, 20);
        tbl[19] = mk(0, 1, 2'b01, 1, 21, 0, 0, 2'b00, 20);
        tbl[20] = mk(0, 0, 2'b01, 1, 21, 0, 0, 2'b00, 20);
        tbl[21] = mk(0, 0, 2'b01, 1, 21, 0, 0, 2'b00, 20);
        tbl[22] = mk(0, 0, 2'b01, 1, 22, 1, 1, 2'b00, 20);
        tbl[23] = mk(0, 0, 2'b00, 1, 0,  0, 1, 2'b01, 22);
        tbl[24] = mk(1, 1, 2'b11, 1, 9,  0, 1, 2'b00, 22);
        tbl[25] = mk(0, 0, 2'b11, 1, 7,  0, 0, 2'b00, 0);
        tbl[26] = mk(0, 0, 2'b11, 1, 7,  0, 0, 2'b00, 0);
        tbl[27] = mk(0, 0, 2'b11, 1, 7,  1, 1, 2'b00, 0);
        tbl[28] = mk(0, 0, 2'b00, 1, 0,  0, 1, 2'b01, 7);

        for (int k = 0; k < 29; k++) apply_vec(k);

        rand_step(1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) rand_step(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
